unidade_busca: RTL and testbench

- Instruction fetch unit. Initiator side of the instruction-memory read port: drives the 8-bit address and captures the 8-bit instruction returned.
- The memory latches `Instrucao = mem[Endereco]` on the falling edge of Clock. An address registered at posedge k therefore returns data valid at posedge k+1.
- Buffers fetched instructions in a small FIFO and presents them to decode with a valid/ready handshake.
- Supports branch redirect with flush, and a fetch enable.

---
 rtl/busca_pkg.sv | 21 ++
 rtl/fila_busca.sv | 72 +++++++
 rtl/unidade_busca.sv | 128 ++++++++++++
 tb/tb_unidade_busca.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/busca_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Entry layout and counter saturation helper used by unidade_busca.
package busca_pkg;

    localparam int LARG_END_PADRAO   = 8;
    localparam int LARG_INSTR_PADRAO = 8;

    localparam logic [15:0] CONT_SAT = 16'hFFFF;

    typedef struct packed {
        logic [LARG_END_PADRAO-1:0]   pc;
        logic [LARG_INSTR_PADRAO-1:0] instr;
    } entrada_t;

    function automatic logic [15:0] soma_sat(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? CONT_SAT : s[15:0];
    endfunction

endpackage

// File: rtl/fila_busca.sv
// Synchronous prefetch FIFO; flush overrides push and pop.
// Head entry is read straight from the storage registers.
module fila_busca #(
    parameter int LARG = 16,
    parameter int PROF = 2,
    localparam int LP  = $clog2(PROF),
    localparam int LC  = LP + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            flush_i,
    input  logic [LARG-1:0] dado_i,
    output logic [LARG-1:0] cabeca_o,
    output logic [LC-1:0]   ocup_o
);

    logic [LARG-1:0] mem_q [PROF];
    logic [LARG-1:0] mem_d [PROF];
    logic [LP-1:0]   esc_q, esc_d, lei_q, lei_d;
    logic [LC-1:0]   ocup_q, ocup_d;
    logic            pop_ef_s;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        esc_d    = esc_q;
        lei_d    = lei_q;
        ocup_d   = ocup_q;
        pop_ef_s = pop_i && (ocup_q != {LC{1'b0}});
        if (flush_i) begin
            esc_d  = {LP{1'b0}};
            lei_d  = {LP{1'b0}};
            ocup_d = {LC{1'b0}};
        end else begin
            if (push_i) begin
                mem_d[esc_q] = dado_i;
                esc_d        = esc_q + LP'(1);
            end else begin
                esc_d = esc_q;
            end
            if (pop_ef_s) begin
                lei_d = lei_q + LP'(1);
            end else begin
                lei_d = lei_q;
            end
            ocup_d = ocup_q + LC'(push_i) - LC'(pop_ef_s);
        end
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PROF; i++) begin
                mem_q[i] <= {LARG{1'b0}};
            end
            esc_q  <= {LP{1'b0}};
            lei_q  <= {LP{1'b0}};
            ocup_q <= {LC{1'b0}};
        end else begin
            mem_q  <= mem_d;
            esc_q  <= esc_d;
            lei_q  <= lei_d;
            ocup_q <= ocup_d;
        end
    end

    assign cabeca_o = mem_q[lei_q];
    assign ocup_o   = ocup_q;

endmodule

// File: rtl/unidade_busca.sv
// Instruction fetch unit: PC, single outstanding read tracking, issue and redirect.
// Optional BUSCA_CONTADORES_EN adds fetch/flush statistics counters.
module unidade_busca
    import busca_pkg::*;
#(
    parameter int                  LARG_END   = LARG_END_PADRAO,
    parameter int                  LARG_INSTR = LARG_INSTR_PADRAO,
    parameter int                  PROF_FILA  = 2,
    parameter logic [LARG_END-1:0] PC_INICIAL = {LARG_END{1'b0}}
) (
    input  logic                  Clock,
    input  logic                  Reset,
    output logic [LARG_END-1:0]   Endereco,
    input  logic [LARG_INSTR-1:0] Instrucao,
    input  logic                  Habilita,
    input  logic                  Desvio,
    input  logic [LARG_END-1:0]   AlvoDesvio,
    output logic                  InstrValida,
    output logic [LARG_INSTR-1:0] InstrSaida,
    output logic [LARG_END-1:0]   PCSaida,
`ifdef BUSCA_CONTADORES_EN
    output logic [15:0]           ContBuscas,
    output logic [15:0]           ContDescartes,
`endif
    input  logic                  Pronto
);

    localparam int                  LC = $clog2(PROF_FILA) + 1;
    localparam logic [LARG_END-1:0] UM = LARG_END'(1);

    logic [LARG_END-1:0] endereco_q, endereco_d;
    logic [LARG_END-1:0] prox_pc_q, prox_pc_d;
    logic                em_voo_q, em_voo_d;
    logic [LC-1:0]       ocup_s, ocup_apos_s;
    logic                push_s, pop_s, emite_s;
    logic [LARG_END+LARG_INSTR-1:0] cabeca_s;

    // The in-flight address is always the held Endereco, so no separate copy is kept.
    assign push_s      = em_voo_q && !Desvio;
    assign pop_s       = (ocup_s != {LC{1'b0}}) && Pronto && !Desvio;
    assign ocup_apos_s = ocup_s + LC'(push_s) - LC'(pop_s);
    assign emite_s     = Habilita && (ocup_apos_s < LC'(PROF_FILA));

    fila_busca #(
        .LARG (LARG_END + LARG_INSTR),
        .PROF (PROF_FILA)
    ) u_fila (
        .clk      (Clock),
        .rst_n    (Reset),
        .push_i   (push_s),
        .pop_i    (pop_s),
        .flush_i  (Desvio),
        .dado_i   ({endereco_q, Instrucao}),
        .cabeca_o (cabeca_s),
        .ocup_o   (ocup_s)
    );

    // Issue and redirect decision.
    always_comb begin
        endereco_d = endereco_q;
        prox_pc_d  = prox_pc_q;
        em_voo_d   = 1'b0;
        if (Desvio) begin
            if (Habilita) begin
                endereco_d = AlvoDesvio;
                prox_pc_d  = AlvoDesvio + UM;
                em_voo_d   = 1'b1;
            end else begin
                prox_pc_d  = AlvoDesvio;
                em_voo_d   = 1'b0;
            end
        end else if (emite_s) begin
            endereco_d = prox_pc_q;
            prox_pc_d  = prox_pc_q + UM;
            em_voo_d   = 1'b1;
        end else begin
            em_voo_d   = 1'b0;
        end
    end

    // PC and outstanding-read registers.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            endereco_q <= PC_INICIAL;
            prox_pc_q  <= PC_INICIAL;
            em_voo_q   <= 1'b0;
        end else begin
            endereco_q <= endereco_d;
            prox_pc_q  <= prox_pc_d;
            em_voo_q   <= em_voo_d;
        end
    end

    assign Endereco    = endereco_q;
    assign InstrValida = (ocup_s != {LC{1'b0}});
    assign PCSaida     = cabeca_s[LARG_END+LARG_INSTR-1:LARG_INSTR];
    assign InstrSaida  = cabeca_s[LARG_INSTR-1:0];

`ifdef BUSCA_CONTADORES_EN
    logic [15:0] buscas_q, buscas_d, descartes_q, descartes_d;

    // Flushed work counts queued entries plus the discarded in-flight read.
    always_comb begin
        buscas_d    = soma_sat(buscas_q, 16'(push_s));
        descartes_d = descartes_q;
        if (Desvio) begin
            descartes_d = soma_sat(descartes_q, 16'(ocup_s) + 16'(em_voo_q));
        end else begin
            descartes_d = descartes_q;
        end
    end

    // Statistics counter registers.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            buscas_q    <= 16'h0000;
            descartes_q <= 16'h0000;
        end else begin
            buscas_q    <= buscas_d;
            descartes_q <= descartes_d;
        end
    end

    assign ContBuscas    = buscas_q;
    assign ContDescartes = descartes_q;
`endif

endmodule

// File: tb/tb_unidade_busca.sv
// Bench for unidade_busca: queue-based reference model plus directed literal checks.
module tb_unidade_busca;
    import busca_pkg::*;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Habilita, Desvio, Pronto;
    logic [7:0] AlvoDesvio;
    logic [7:0] Endereco0, Instrucao0, InstrSaida0, PCSaida0;
    logic       InstrValida0;
    logic [7:0] Endereco1, Instrucao1, InstrSaida1, PCSaida1;
    logic       InstrValida1;
`ifdef BUSCA_CONTADORES_EN
    logic [15:0] ContBuscas0, ContDescartes0, ContBuscas1, ContDescartes1;
`endif

    logic [7:0] mem [256];
    int n_testes = 0;
    int n_falhas = 0;
    logic chk_en = 1'b0;

    entrada_t   fila[$];
    logic       m_voo;
    logic [7:0] m_end, m_npc;
    int         m_buscas, m_desc;

    always #5 Clock = ~Clock;

    unidade_busca #(.PC_INICIAL(8'h00)) dut0 (
        .Clock(Clock), .Reset(Reset), .Endereco(Endereco0), .Instrucao(Instrucao0),
        .Habilita(Habilita), .Desvio(Desvio), .AlvoDesvio(AlvoDesvio),
        .InstrValida(InstrValida0), .InstrSaida(InstrSaida0), .PCSaida(PCSaida0),
`ifdef BUSCA_CONTADORES_EN
        .ContBuscas(ContBuscas0), .ContDescartes(ContDescartes0),
`endif
        .Pronto(Pronto)
    );

    unidade_busca #(.PC_INICIAL(8'hFE)) dut1 (
        .Clock(Clock), .Reset(Reset), .Endereco(Endereco1), .Instrucao(Instrucao1),
        .Habilita(1'b1), .Desvio(1'b0), .AlvoDesvio(8'h00),
        .InstrValida(InstrValida1), .InstrSaida(InstrSaida1), .PCSaida(PCSaida1),
`ifdef BUSCA_CONTADORES_EN
        .ContBuscas(ContBuscas1), .ContDescartes(ContDescartes1),
`endif
        .Pronto(1'b1)
    );

    // Memory answers on the falling edge for the address currently presented.
    always @(negedge Clock) begin
        Instrucao0 = mem[Endereco0];
        Instrucao1 = mem[Endereco1];
    end

    task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
        n_testes++;
        if (got !== exp) begin
            n_falhas++;
            $display("FAIL %s: got %0h expected %0h at %0t", nome, got, exp, $time);
        end
    endtask

    // Reference model: a queue of fetched entries, one outstanding read.
    always @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            fila.delete();
            m_voo = 1'b0; m_end = 8'h00; m_npc = 8'h00;
            m_buscas = 0; m_desc = 0;
        end else if (Desvio) begin
            m_desc = m_desc + fila.size() + int'(m_voo);
            if (m_desc > 65535) m_desc = 65535;
            fila.delete();
            if (Habilita) begin
                m_end = AlvoDesvio; m_npc = AlvoDesvio + 8'd1; m_voo = 1'b1;
            end else begin
                m_npc = AlvoDesvio; m_voo = 1'b0;
            end
        end else begin
            automatic bit tinha = (fila.size() > 0);
            if (m_voo) begin
                fila.push_back({m_end, mem[m_end]});
                if (m_buscas < 65535) m_buscas++;
            end
            if (tinha && Pronto) void'(fila.pop_front());
            if (Habilita && fila.size() < 2) begin
                m_end = m_npc; m_npc = m_npc + 8'd1; m_voo = 1'b1;
            end else begin
                m_voo = 1'b0;
            end
        end
    end

    // Per-cycle comparison of dut0 against the model.
    always @(negedge Clock) begin
        if (chk_en && Reset) begin
            check("endereco", 32'(Endereco0), 32'(m_end));
            check("valida", 32'(InstrValida0), 32'(fila.size() > 0));
            if (fila.size() > 0) begin
                check("pc_saida", 32'(PCSaida0), 32'(fila[0].pc));
                check("instr_saida", 32'(InstrSaida0), 32'(fila[0].instr));
            end
`ifdef BUSCA_CONTADORES_EN
            check("cont_buscas", 32'(ContBuscas0), 32'(m_buscas));
            check("cont_descartes", 32'(ContDescartes0), 32'(m_desc));
`endif
        end
    end

    initial begin
        Reset = 1'b0; Habilita = 1'b1; Pronto = 1'b1; Desvio = 1'b0; AlvoDesvio = 8'h00;
        Instrucao0 = 8'h00; Instrucao1 = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i + 16);

        @(negedge Clock); @(negedge Clock);
        check("rst_endereco", 32'(Endereco0), 32'h00);
        check("rst_valida", 32'(InstrValida0), 32'h0);
        check("rst_instr", 32'(InstrSaida0), 32'h00);
        check("rst_pc", 32'(PCSaida0), 32'h00);
        check("rst_endereco_fe", 32'(Endereco1), 32'hFE);
        Reset = 1'b1; chk_en = 1'b1;

        // Edges 1..6 with free flow: Endereco 0,1,2..; head (k-2, k-2+10h).
        for (int k = 1; k <= 6; k++) begin
            automatic logic [7:0] e = 8'(k - 2);
            automatic logic [7:0] e1 = 8'(254 + k - 2);
            @(negedge Clock);
            check("seq_endereco", 32'(Endereco0), 32'(k - 1));
            check("seq_valida", 32'(InstrValida0), 32'(k >= 2));
            if (k >= 2) begin
                check("seq_pc", 32'(PCSaida0), 32'(e));
                check("seq_instr", 32'(InstrSaida0), 32'(8'(e + 8'h10)));
            end
            if (k >= 2 && k <= 5) begin
                check("wrap_pc", 32'(PCSaida1), 32'(e1));
                check("wrap_instr", 32'(InstrSaida1), 32'(8'(e1 + 8'h10)));
            end
        end

        // Stall edges 7..11: FIFO fills with pcs 4 and 5, Endereco frozen at 5.
        Pronto = 1'b0;
        repeat (5) @(negedge Clock);
        check("stall_endereco", 32'(Endereco0), 32'h05);
        check("stall_pc", 32'(PCSaida0), 32'h04);
        check("stall_valida", 32'(InstrValida0), 32'h1);

        // Redirect to 40h with two queued entries and Pronto high.
        Desvio = 1'b1; AlvoDesvio = 8'h40; Pronto = 1'b1;
        @(negedge Clock);
        Desvio = 1'b0;
        check("desvio_valida", 32'(InstrValida0), 32'h0);
        check("desvio_endereco", 32'(Endereco0), 32'h40);
`ifdef BUSCA_CONTADORES_EN
        check("desvio_buscas", 32'(ContBuscas0), 32'd6);
        check("desvio_descartes", 32'(ContDescartes0), 32'd2);
`endif
        @(negedge Clock);
        check("alvo_valida", 32'(InstrValida0), 32'h1);
        check("alvo_pc", 32'(PCSaida0), 32'h40);
        check("alvo_instr", 32'(InstrSaida0), 32'h50);

        // Reset mid-cycle with a queue and a read in flight.
        repeat (3) @(negedge Clock);
        Pronto = 1'b0;
        @(negedge Clock);
        #1;
        chk_en = 1'b0; Reset = 1'b0;
        #1;
        check("mrst_endereco", 32'(Endereco0), 32'h00);
        check("mrst_valida", 32'(InstrValida0), 32'h0);
        check("mrst_instr", 32'(InstrSaida0), 32'h00);
        check("mrst_pc", 32'(PCSaida0), 32'h00);
`ifdef BUSCA_CONTADORES_EN
        check("mrst_buscas", 32'(ContBuscas0), 32'h0);
`endif
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        Pronto = 1'b1; Habilita = 1'b1;
        @(negedge Clock);
        Reset = 1'b1; chk_en = 1'b1;
        @(negedge Clock); @(negedge Clock);
        check("refetch_pc", 32'(PCSaida0), 32'h00);
        check("refetch_instr", 32'(InstrSaida0), 32'(mem[0]));

        // Randomized traffic checked cycle by cycle against the model.
        for (int c = 0; c < 3000; c++) begin
            Habilita   = ($urandom_range(9) < 8);
            Pronto     = ($urandom_range(9) < 7);
            Desvio     = ($urandom_range(99) < 8);
            AlvoDesvio = 8'($urandom);
            @(negedge Clock);
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
        $finish;
    end

endmodule
